// File: rtl/result_checker.sv
// ---------------------------------------------------------------------------
// result_checker
//   Scoreboard that sits downstream of the stimulus driver. It realigns the
//   undelayed operands to the DUT latency that the driver measured, computes
//   the golden result and compares it with the DUT output every cycle. It
//   keeps pass/fail statistics and captures the first failing vector.
//
// Parameters
//   WIDTH        operand/result width
//   DEPTH        history depth; the largest supported DUT latency is DEPTH-1
//   OP           golden function: 0 a+b, 1 a-b, 2 a^b, 3 a&b (mod 2^WIDTH)
//   STOP_ON_ERR  1 = halt at the first mismatch, 0 = keep counting
//
// Ports
//   clk_dut       sole clock, rising edge
//   reset         asynchronous, active-high
//   i_drive_a/b   operands as driven to the DUT this cycle
//   i_dut_out     DUT result
//   i_dut_delay   measured DUT latency; all-ones = calibration not finished
//   o_state       00 CAL, 01 CHECK, 10 HALT, 11 BADCFG
//   o_test_count  vectors compared (saturating)
//   o_err_count   mismatches (saturating)
//   o_err         sticky mismatch flag
//   o_first_a/b   operands of the first mismatching vector
//   o_first_out   DUT output of the first mismatching vector
// ---------------------------------------------------------------------------
module result_checker #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 16,
   parameter int OP          = 0,
   parameter int STOP_ON_ERR = 1
) (
   input  logic             clk_dut,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_drive_a,
   input  logic [WIDTH-1:0] i_drive_b,
   input  logic [WIDTH-1:0] i_dut_out,
   input  logic [WIDTH-1:0] i_dut_delay,
   output logic [1:0]       o_state,
   output logic [31:0]      o_test_count,
   output logic [15:0]      o_err_count,
   output logic             o_err,
   output logic [WIDTH-1:0] o_first_a,
   output logic [WIDTH-1:0] o_first_b,
   output logic [WIDTH-1:0] o_first_out
);

   localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;   // latency index width
   localparam int FW = $clog2(DEPTH + 1);                 // fill counter width
   localparam logic [FW-1:0]    FILL_MAX = FW'(DEPTH);
   localparam logic [WIDTH-1:0] DEPTH_W  = WIDTH'(DEPTH);

   typedef enum logic [1:0] {
      ST_CAL    = 2'b00,
      ST_CHECK  = 2'b01,
      ST_HALT   = 2'b10,
      ST_BADCFG = 2'b11
   } state_t;

   state_t                          state_reg;
   logic [DEPTH-1:0][2*WIDTH-1:0]   hist_reg;
   logic [FW-1:0]                   fill_reg;
   logic [DW-1:0]                   delay_reg;

   logic [2*WIDTH-1:0] tap;
   logic [WIDTH-1:0]   tap_a;
   logic [WIDTH-1:0]   tap_b;
   logic [WIDTH-1:0]   golden;
   logic [FW-1:0]      delay_ext;
   logic               cmp_en;
   logic               mismatch;

   assign o_state = state_reg;

   // Latency 0 pairs the output with the operands being driven right now;
   // otherwise the operands come from the history, N-1 entries back.
   always_comb begin
      tap = {i_drive_a, i_drive_b};
      if (delay_reg != '0) begin
         tap = hist_reg[delay_reg - 1'b1];
      end
   end

   assign tap_a = tap[2*WIDTH-1:WIDTH];
   assign tap_b = tap[WIDTH-1:0];

   generate
      if (OP == 1) begin : g_sub
         assign golden = tap_a - tap_b;
      end else if (OP == 2) begin : g_xor
         assign golden = tap_a ^ tap_b;
      end else if (OP == 3) begin : g_and
         assign golden = tap_a & tap_b;
      end else begin : g_add
         assign golden = tap_a + tap_b;
      end
   endgenerate

   // fill counts edges since reset; requiring fill >= N guarantees the tap
   // holds operands actually sampled after reset, never cleared history.
   assign delay_ext = FW'(delay_reg);
   assign cmp_en    = (state_reg == ST_CHECK) && (fill_reg >= delay_ext);
   assign mismatch  = (golden != i_dut_out);

   always_ff @(posedge clk_dut or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_CAL;
         hist_reg     <= '0;
         fill_reg     <= '0;
         delay_reg    <= '0;
         o_test_count <= '0;
         o_err_count  <= '0;
         o_err        <= 1'b0;
         o_first_a    <= '0;
         o_first_b    <= '0;
         o_first_out  <= '0;
      end else begin
         // History shifts in every state so it is primed before CHECK.
         hist_reg[0] <= {i_drive_a, i_drive_b};
         for (int j = 1; j < DEPTH; j++) begin
            hist_reg[j] <= hist_reg[j-1];
         end
         if (fill_reg != FILL_MAX) begin
            fill_reg <= fill_reg + 1'b1;
         end

         case (state_reg)
            ST_CAL: begin
               if (i_dut_delay != '1) begin
                  if (i_dut_delay < DEPTH_W) begin
                     state_reg <= ST_CHECK;
                     delay_reg <= i_dut_delay[DW-1:0];
                  end else begin
                     state_reg <= ST_BADCFG;
                  end
               end
            end
            ST_CHECK: begin
               if (cmp_en) begin
                  if (o_test_count != '1) begin
                     o_test_count <= o_test_count + 32'd1;
                  end
                  if (mismatch) begin
                     if (o_err_count != '1) begin
                        o_err_count <= o_err_count + 16'd1;
                     end
                     o_err <= 1'b1;
                     if (!o_err) begin
                        o_first_a   <= tap_a;
                        o_first_b   <= tap_b;
                        o_first_out <= i_dut_out;
                     end
                  end
                  // Halt once the count would reach all-ones, or on a
                  // mismatch when configured to stop at the first error.
                  if ((o_test_count >= 32'hFFFF_FFFE) ||
                      (mismatch && (STOP_ON_ERR != 0))) begin
                     state_reg <= ST_HALT;
                  end
               end
            end
            default: ;  // HALT and BADCFG hold until reset
         endcase
      end
   end

endmodule

// File: tb/tb_result_checker.sv
module tb_result_checker;

   logic       clk_dut = 1'b0;
   logic       reset;
   logic [7:0] drv_a, drv_b, dut_out, dut_delay;

   // Instance 0: add, stop on error; 1: add, keep counting; 2: subtract, stop.
   logic [1:0]  st  [3];
   logic [31:0] tc  [3];
   logic [15:0] ec  [3];
   logic        err [3];
   logic [7:0]  fa  [3];
   logic [7:0]  fb  [3];
   logic [7:0]  fo  [3];

   always #5 clk_dut = ~clk_dut;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         result_checker #(
            .WIDTH(8), .DEPTH(16),
            .OP((gi == 2) ? 1 : 0),
            .STOP_ON_ERR((gi == 1) ? 0 : 1)
         ) u_dut (
            .clk_dut(clk_dut), .reset(reset),
            .i_drive_a(drv_a), .i_drive_b(drv_b),
            .i_dut_out(dut_out), .i_dut_delay(dut_delay),
            .o_state(st[gi]), .o_test_count(tc[gi]), .o_err_count(ec[gi]),
            .o_err(err[gi]), .o_first_a(fa[gi]), .o_first_b(fb[gi]),
            .o_first_out(fo[gi])
         );
      end
   endgenerate

   typedef struct {
      int          inst;
      logic [1:0]  st;
      logic [31:0] tc;
      logic [15:0] ec;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   logic [7:0]  dq[$];          // two-cycle adder DUT model
   logic [1:0]  m_st  [3];
   logic [31:0] m_tc  [3];
   logic [15:0] m_ec  [3];
   logic        m_err [3];
   int          m_n   [3];
   int          n_edges;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(string tag, int inst, logic [31:0] obs, logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, inst, obs, expv);
      end
   endtask

   // Expected effect of one clock edge on checker i; bad = the DUT output
   // presented at this edge is known to be corrupted.
   task automatic mdl_edge(int i, bit bad);
      case (m_st[i])
         2'b00: begin
            if (dut_delay != 8'hFF) begin
               if (dut_delay < 8'd16) begin
                  m_st[i] = 2'b01;
                  m_n[i]  = int'(dut_delay);
               end else begin
                  m_st[i] = 2'b11;
               end
            end
         end
         2'b01: begin
            if (n_edges >= m_n[i]) begin
               m_tc[i]++;
               if (bad) begin
                  m_ec[i]++;
                  m_err[i] = 1'b1;
                  if (i != 1) m_st[i] = 2'b10;
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic step(logic [7:0] a, logic [7:0] b, logic [7:0] o, bit bad, logic [2:0] mask);
      drv_a   = a;
      drv_b   = b;
      dut_out = o;
      for (int i = 0; i < 3; i++) begin
         if (mask[i]) begin
            exp_t e;
            mdl_edge(i, bad);
            e.inst = i; e.st = m_st[i]; e.tc = m_tc[i]; e.ec = m_ec[i]; e.err = m_err[i];
            sb_q.push_back(e);
         end
      end
      n_edges++;
      @(posedge clk_dut);
      #1;
      while (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk("state",      e.inst, 32'(st[e.inst]),  32'(e.st));
         chk("test_count", e.inst, tc[e.inst],       e.tc);
         chk("err_count",  e.inst, 32'(ec[e.inst]),  32'(e.ec));
         chk("err",        e.inst, 32'(err[e.inst]), 32'(e.err));
      end
      @(negedge clk_dut);
   endtask

   // Asserts reset between clock edges and checks the asynchronous clear.
   task automatic do_reset();
      #3;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_state", i, 32'(st[i]), 32'd0);
         chk("rst_tc",    i, tc[i],      32'd0);
         chk("rst_ec",    i, 32'(ec[i]), 32'd0);
         chk("rst_err",   i, 32'(err[i]), 32'd0);
         chk("rst_fa",    i, 32'(fa[i]), 32'd0);
         chk("rst_fb",    i, 32'(fb[i]), 32'd0);
         chk("rst_fo",    i, 32'(fo[i]), 32'd0);
         m_st[i] = 2'b00; m_tc[i] = '0; m_ec[i] = '0; m_err[i] = 1'b0; m_n[i] = 0;
      end
      drv_a = '0; drv_b = '0; dut_out = '0;
      dq.delete();
      sb_q.delete();
      n_edges = 0;
      @(negedge clk_dut);
      reset = 1'b0;
   endtask

   // a=i, b=2i into a two-cycle adder; optionally corrupt vectors 16, 20, 24.
   task automatic run_stream(int n, bit corrupt);
      for (int i = 0; i < n; i++) begin
         logic [7:0] a, b, o;
         bit         bad;
         a = 8'(i);
         b = 8'(2 * i);
         dq.push_back(a + b);
         o   = '0;
         bad = 1'b0;
         if (dq.size() > 2) begin
            o = dq.pop_front();
            if (corrupt && ((i - 2) == 16 || (i - 2) == 20 || (i - 2) == 24)) begin
               o   = o ^ 8'h01;
               bad = 1'b1;
            end
         end
         step(a, b, o, bad, 3'b011);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ra, rb;
      reset     = 1'b0;
      dut_delay = 8'd2;
      drv_a = '0; drv_b = '0; dut_out = '0;
      do_reset();

      // Clean adder stream, latency 2.
      run_stream(20, 1'b0);

      // Three corrupted vectors; instance 0 halts at the first.
      do_reset();
      run_stream(30, 1'b1);
      for (int i = 0; i < 2; i++) begin
         chk("first_a",   i, 32'(fa[i]), 32'h10);
         chk("first_b",   i, 32'(fb[i]), 32'h20);
         chk("first_out", i, 32'(fo[i]), 32'h31);
      end

      // Reset mid-CHECK after errors, then a fresh run behaves the same.
      do_reset();
      run_stream(20, 1'b0);

      // Calibration pending for 100 cycles, then an unsupported latency.
      do_reset();
      dut_delay = 8'hFF;
      for (int i = 0; i < 100; i++) step(8'(i), 8'(2 * i), 8'h00, 1'b0, 3'b001);
      dut_delay = 8'd16;
      for (int i = 0; i < 3; i++) step(8'(i), 8'(i), 8'h00, 1'b0, 3'b001);

      // Subtractor, latency 0: wrap-around, ignored latency change, one error.
      do_reset();
      dut_delay = 8'd0;
      step(8'h00, 8'h01, 8'hFF, 1'b0, 3'b100);
      for (int k = 0; k < 10; k++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         if (k == 5) dut_delay = 8'd3;
         step(ra, rb, ra - rb, 1'b0, 3'b100);
      end
      step(8'h40, 8'h05, 8'hBB, 1'b1, 3'b100);
      chk("first_a",   2, 32'(fa[2]), 32'h40);
      chk("first_b",   2, 32'(fb[2]), 32'h05);
      chk("first_out", 2, 32'(fo[2]), 32'hBB);
      step(8'h01, 8'h01, 8'h77, 1'b0, 3'b100);
      step(8'h02, 8'h01, 8'h01, 1'b0, 3'b100);
      chk("first_out_hold", 2, 32'(fo[2]), 32'hBB);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_checker.md
Name: result_checker

Overview:
- Downstream of the stimulus driver; acts as the testbench scoreboard.
- Takes the undelayed operands sent to the DUT, the DUT result, and the DUT latency that the driver measured.
- Realigns the operands to the measured latency, computes the golden result and compares it with the DUT output every cycle.
- Keeps pass/fail statistics and captures the first failing vector for readout.

Parameters:
WIDTH, 32, operand/result width
DEPTH, 16, history depth; largest supported DUT latency is DEPTH-1
OP, 0, golden function: 0 a+b, 1 a-b, 2 a^b, 3 a&b (all mod 2^WIDTH)
STOP_ON_ERR, 1, 1 = halt at first mismatch; 0 = keep counting

Ports:
clk_dut  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high
i_drive_a  in  WIDTH  operand A as driven to DUT this cycle
i_drive_b  in  WIDTH  operand B as driven to DUT this cycle
i_dut_out  in  WIDTH  DUT result
i_dut_delay  in  WIDTH  measured DUT latency; all-ones = calibration not finished
o_state  out  2  00 CAL, 01 CHECK, 10 HALT, 11 BADCFG
o_test_count  out  32  vectors compared, saturating
o_err_count  out  16  mismatches, saturating
o_err  out  1  sticky mismatch flag
o_first_a  out  WIDTH  operand A of first mismatch
o_first_b  out  WIDTH  operand B of first mismatch
o_first_out  out  WIDTH  DUT output of first mismatch

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high. Reset drives every register and output to 0, o_state to CAL, and clears the history.
- History buffer: DEPTH-entry shift register holding {a,b}.
  - Every edge, including in CAL: hist[0]<=i_drive, hist[j]<=hist[j-1].
  - Pre-update, hist[j] at edge k holds the operands sampled at edge k-1-j.
- Alignment, with N = i_dut_delay:
  - i_dut_out sampled at edge k is paired with the operands sampled at edge k-N.
  - Tap = current i_drive when N=0, else hist[N-1] (pre-update).
- Fill counter: counts edges since reset, saturating at DEPTH.
  - A compare is enabled only when state=CHECK and fill>=N.
  - No stale or reset-zero history is ever checked.
- Golden: exp = OP(tap_a, tap_b), truncated to WIDTH bits; subtraction wraps.
- Compare:
  - Combinational compare; results registered at the same edge at which the output is sampled, so counters and flags are visible one edge after the vector is presented.
  - Each enabled compare: o_test_count+1.
  - On mismatch: o_err_count+1 and o_err<=1.
  - If o_err was 0 at that edge, o_first_a/b/out latch tap_a, tap_b, i_dut_out. They are never overwritten until reset.
- All-zero operand vectors (driver calibration markers) are checked like any other vector.
- State machine:
  - CAL: N all-ones -> stay. N<DEPTH -> CHECK. Otherwise -> BADCFG.
  - CHECK:
    - Mismatch with STOP_ON_ERR=1 -> HALT.
    - o_test_count reaching all-ones -> HALT.
    - Otherwise stay.
    - i_dut_delay is treated as static. A change in CHECK is ignored and the value latched on leaving CAL is used.
  - HALT, BADCFG: terminal until reset. No counter or capture updates.
- Simultaneous events:
  - A mismatch on the compare that saturates o_test_count is counted and captured, then the block goes to HALT.
  - In CAL->CHECK on edge k, the first compare can occur no earlier than edge k+1.
- Saturation: o_test_count and o_err_count hold at all-ones; they never wrap.
- Reset mid-operation: everything clears immediately; the block returns to CAL and fill restarts from 0.

Test Plan:
- WIDTH=8, OP=0, N=2. Stream a=i, b=2i. DUT model is an adder plus two-cycle delay. -> CHECK; o_err=0; o_test_count = edges in CHECK (with fill>=2); o_state=01.
- Same stream, DUT output corrupted once (a=0x10,b=0x20, out=0x31), STOP_ON_ERR=1. -> o_err=1, o_err_count=1, first_a=0x10, first_b=0x20, first_out=0x31, o_state=10, counters then frozen.
- STOP_ON_ERR=0, three corrupted vectors. -> o_err_count=3; first_* hold the first bad vector; state stays CHECK.
- i_dut_delay=0xFF for 100 cycles, then 16 (DEPTH=16). -> CAL for 100 cycles, then BADCFG (11), o_test_count=0.
- N=0, OP=1, a=0x00, b=0x01, out=0xFF. -> pass (wraps); compare starts on the first CHECK edge.
- Assert reset mid-CHECK after errors. -> all outputs 0 and o_state=CAL asynchronously; after release, behaviour is identical to a fresh run.
